// File: rtl/wb_pkg.sv
// Shared types for the MEM->WB stage: writeback source select and default widths.
package wb_pkg;
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam int XLEN_DEF = 32;
endpackage

// File: rtl/wb_stage_reg_if.sv
// MEM-side payload in, WB-side registered view out; slave is the stage register.
interface wb_stage_reg_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               valid_M;
    logic               reg_write_M;
    logic [1:0]         result_src_M;
    logic [XLEN-1:0]    alu_result_M;
    logic [XLEN-1:0]    read_data_M;
    logic [RADDR_W-1:0] rd_M;
    logic [XLEN-1:0]    pc_plus4_M;

    logic               valid_W;
    logic               reg_write_W;
    logic [RADDR_W-1:0] rd_W;
    logic [XLEN-1:0]    result_W;
    logic [XLEN-1:0]    alu_result_W;
    logic [XLEN-1:0]    read_data_W;
    logic [XLEN-1:0]    pc_plus4_W;

    modport master (
        output valid_M, reg_write_M, result_src_M, alu_result_M, read_data_M, rd_M, pc_plus4_M,
        input  valid_W, reg_write_W, rd_W, result_W, alu_result_W, read_data_W, pc_plus4_W
    );
    modport slave (
        input  valid_M, reg_write_M, result_src_M, alu_result_M, read_data_M, rd_M, pc_plus4_M,
        output valid_W, reg_write_W, rd_W, result_W, alu_result_W, read_data_W, pc_plus4_W
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear beats increment and the count sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_q <= '0;
        else if (i_clr)              r_q <= '0;
        else if (i_inc && ~&r_q)     r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;
endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: stall/flush control, writeback select, gated rd write,
// and retired/bubble performance counters.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_W,
    input  logic             flush_W,
    input  logic             cnt_clr,
    wb_stage_reg_if.slave    bus,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic               r_valid;
    logic               r_reg_write;
    logic [1:0]         r_src;
    logic [XLEN-1:0]    r_alu;
    logic [XLEN-1:0]    r_rdata;
    logic [RADDR_W-1:0] r_rd;
    logic [XLEN-1:0]    r_pc4;
    logic [XLEN-1:0]    w_result;

    // A flush only kills the slot; payload is left alone so forwarding sources stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_src       <= '0;
            r_alu       <= '0;
            r_rdata     <= '0;
            r_rd        <= '0;
            r_pc4       <= '0;
        end else if (flush_W) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!stall_W) begin
            r_valid     <= bus.valid_M;
            r_reg_write <= bus.reg_write_M;
            r_src       <= bus.result_src_M;
            r_alu       <= bus.alu_result_M;
            r_rdata     <= bus.read_data_M;
            r_rd        <= bus.rd_M;
            r_pc4       <= bus.pc_plus4_M;
        end
    end

    // Reserved code 2'b11 falls back to the ALU result.
    always_comb begin
        w_result = r_alu;
        case (r_src)
            RES_MEM: w_result = r_rdata;
            RES_PC4: w_result = r_pc4;
            default: w_result = r_alu;
        endcase
    end

    assign bus.valid_W      = r_valid;
    assign bus.reg_write_W  = r_reg_write & r_valid & (|r_rd);
    assign bus.rd_W         = r_rd;
    assign bus.result_W     = w_result;
    assign bus.alu_result_W = r_alu;
    assign bus.read_data_W  = r_rdata;
    assign bus.pc_plus4_W   = r_pc4;

    // Counters look at the slot leaving WB, i.e. the pre-edge valid, regardless of flush.
    sat_counter #(.W(CNT_W)) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (r_valid & ~stall_W),
        .i_clr (cnt_clr),
        .o_q   (retired_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (~r_valid & ~stall_W),
        .i_clr (cnt_clr),
        .o_q   (bubble_cnt)
    );
endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed plus randomized bench for wb_stage_reg against a transaction-level model.
module tb_wb_stage_reg;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_W = 1'b0, flush_W = 1'b0, cnt_clr = 1'b0;
    logic [CNT_W-1:0] retired_cnt, bubble_cnt;

    int tests = 0;
    int fails = 0;

    wb_stage_reg_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

    wb_stage_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_W     (stall_W),
        .flush_W     (flush_W),
        .cnt_clr     (cnt_clr),
        .bus         (bus),
        .retired_cnt (retired_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference: what instruction occupies WB, and how many slots have passed.
    typedef struct {
        bit          valid;
        bit          rw;
        bit [1:0]    src;
        bit [31:0]   alu, rdata, pc4;
        bit [4:0]    rd;
    } slot_t;

    slot_t ws;
    int    n_ret, n_bub;

    function automatic bit [31:0] pick(slot_t s);
        if (s.src == 2'd1) return s.rdata;
        if (s.src == 2'd2) return s.pc4;
        return s.alu;
    endfunction

    function automatic bit writes(slot_t s);
        return s.valid && s.rw && (s.rd != 5'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  64'(bus.valid_W),      64'(ws.valid));
        chk({tag, ".rw"},     64'(bus.reg_write_W),  64'(writes(ws)));
        chk({tag, ".rd"},     64'(bus.rd_W),         64'(ws.rd));
        chk({tag, ".result"}, 64'(bus.result_W),     64'(pick(ws)));
        chk({tag, ".alu"},    64'(bus.alu_result_W), 64'(ws.alu));
        chk({tag, ".rdata"},  64'(bus.read_data_W),  64'(ws.rdata));
        chk({tag, ".pc4"},    64'(bus.pc_plus4_W),   64'(ws.pc4));
        chk({tag, ".ret"},    64'(retired_cnt),      64'(n_ret));
        chk({tag, ".bub"},    64'(bubble_cnt),       64'(n_bub));
    endtask

    task automatic model_reset();
        ws = '{default: 0};
        n_ret = 0;
        n_bub = 0;
    endtask

    task automatic drive_m(input bit v, input bit rw, input bit [1:0] src,
                           input bit [31:0] alu, input bit [31:0] rdata,
                           input bit [4:0] rd, input bit [31:0] pc4);
        bus.valid_M = v;   bus.reg_write_M = rw; bus.result_src_M = src;
        bus.alu_result_M = alu; bus.read_data_M = rdata;
        bus.rd_M = rd;     bus.pc_plus4_M = pc4;
    endtask

    task automatic drive_rand();
        drive_m(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                5'($urandom), $urandom);
    endtask

    // One clock with the given controls; the model advances at the edge, outputs checked 1ns later.
    task automatic step(input string tag, input bit st, input bit fl, input bit clr);
        stall_W = st; flush_W = fl; cnt_clr = clr;
        @(posedge clk);
        if (clr) begin
            n_ret = 0; n_bub = 0;
        end else if (!st) begin
            if (ws.valid) n_ret = (n_ret < CMAX) ? n_ret + 1 : CMAX;
            else          n_bub = (n_bub < CMAX) ? n_bub + 1 : CMAX;
        end
        if (fl) begin
            ws.valid = 0; ws.rw = 0;
        end else if (!st) begin
            ws.valid = bus.valid_M; ws.rw = bus.reg_write_M; ws.src = bus.result_src_M;
            ws.alu = bus.alu_result_M; ws.rdata = bus.read_data_M;
            ws.rd = bus.rd_M; ws.pc4 = bus.pc_plus4_M;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        slot_t a;

        // Reset held with junk on the inputs.
        model_reset();
        drive_rand();
        stall_W = 1'($urandom); flush_W = 1'($urandom); cnt_clr = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        drive_m(1, 1, 2'b00, 32'h1234, $urandom, 5'd5, $urandom);
        step("load1", 0, 0, 0);
        chk("load1.result_fixed", 64'(bus.result_W), 64'h1234);
        chk("load1.rw_fixed",     64'(bus.reg_write_W), 64'd1);

        // Writeback mux.
        drive_m(1, 1, 2'b01, 32'h1111, 32'hDEADBEEF, 5'd7, 32'h100);
        step("mux_mem", 0, 0, 0);
        chk("mux_mem.fixed", 64'(bus.result_W), 64'hDEADBEEF);
        drive_m(1, 1, 2'b10, 32'h2222, 32'h3333, 5'd7, 32'h104);
        step("mux_pc4", 0, 0, 0);
        chk("mux_pc4.fixed", 64'(bus.result_W), 64'h104);
        drive_m(1, 1, 2'b11, 32'h5555AAAA, 32'h3333, 5'd7, 32'h108);
        step("mux_rsv", 0, 0, 0);
        chk("mux_rsv.fixed", 64'(bus.result_W), 64'h5555AAAA);

        // x0 and invalid-slot gating.
        drive_m(1, 1, 2'b00, $urandom, $urandom, 5'd0, $urandom);
        step("x0", 0, 0, 0);
        chk("x0.rw_fixed", 64'(bus.reg_write_W), 64'd0);
        drive_m(0, 1, 2'b00, $urandom, $urandom, 5'd3, $urandom);
        step("inval", 0, 0, 0);
        chk("inval.rw_fixed", 64'(bus.reg_write_W), 64'd0);

        // Stall: A stays put while B waits on the M side.
        drive_m(1, 1, 2'b00, 32'hA0A0, 32'hA1A1, 5'd9, 32'hA4);
        step("stallA", 0, 0, 0);
        a = ws;
        drive_m(1, 1, 2'b01, 32'hB0B0, 32'hB1B1, 5'd10, 32'hB4);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0);
        chk("stall.alu_fixed", 64'(bus.alu_result_W), 64'(a.alu));
        chk("stall.ret_held",  64'(retired_cnt), 64'(n_ret));
        step("stall_drop", 0, 0, 0);
        chk("stall_drop.result_fixed", 64'(bus.result_W), 64'hB1B1);

        // Flush beats stall; payload untouched.
        drive_rand();
        step("flush_stall", 1, 1, 0);
        chk("flush_stall.rdata_fixed", 64'(bus.read_data_W), 64'hB1B1);

        // Counter saturation at 4 bits, then clear racing an increment.
        step("clr", 0, 0, 1);
        drive_m(1, 1, 2'b00, $urandom, $urandom, 5'd1, $urandom);
        for (int i = 0; i < 20; i++) step("sat", 0, 0, 0);
        chk("sat.ret_fixed", 64'(retired_cnt), 64'd15);
        step("clr_inc", 0, 0, 1);
        chk("clr_inc.ret_fixed", 64'(retired_cnt), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            drive_rand();
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 30) == 0));
        end

        // Asynchronous reset between edges, with a stall pending.
        drive_rand();
        stall_W = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        drive_m(1, 1, 2'b10, $urandom, $urandom, 5'd12, 32'h200);
        step("post_rst", 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            step("rand2", ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
